// File: rtl/hough_frame_sched.sv
// hough_frame_sched
//   Per-frame sequencer for the Hough accumulator RAM. The RAM is handed to
//   three phases in turn: clear (zero every bin), vote (forward edge pixels)
//   and peak search (external engine, started/finished by a handshake).
//   Completed, dropped and short frames are reported.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              level-sensitive run request
//   img_vsync           frame sync, rising edge marks frame start
//   img_de, edge_bit    active-pixel strobe and binarised edge flag
//   x_axis, y_axis      pixel coordinates, valid with img_de
//   search_done         one-cycle completion pulse from the peak search
//   acc_clr_en/_addr    accumulator clear write strobe and address
//   vote_en, vote_x/y   registered vote for an edge pixel
//   search_start        one-cycle pulse on entry to the search phase
//   frame_done          one-cycle pulse, accumulator result valid
//   frame_cnt           completed frames (wrapping)
//   skip_cnt            dropped frame starts (saturating)
//   frame_err           one-cycle pulse, short frame discarded
//   busy                sequencer not idle
module hough_frame_sched #(
   parameter int H_DISP    = 640,
   parameter int V_DISP    = 480,
   parameter int ACC_DEPTH = 46080,
   parameter int ACC_AW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              img_vsync,
   input  logic              img_de,
   input  logic              edge_bit,
   input  logic [11:0]       x_axis,
   input  logic [11:0]       y_axis,
   input  logic              search_done,
   output logic              acc_clr_en,
   output logic [ACC_AW-1:0] acc_clr_addr,
   output logic              vote_en,
   output logic [11:0]       vote_x,
   output logic [11:0]       vote_y,
   output logic              search_start,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic [7:0]        skip_cnt,
   output logic              frame_err,
   output logic              busy
);

   localparam logic [18:0]       PIX_LAST = 19'(H_DISP * V_DISP - 1);
   localparam logic [ACC_AW-1:0] CLR_LAST = ACC_AW'(ACC_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_FRM, S_VOTE, S_SEARCH, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              vsync_q;
   logic [ACC_AW-1:0] clr_addr_q, clr_addr_d;
   logic [18:0]       pix_cnt_q, pix_cnt_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [7:0]        skip_cnt_q, skip_cnt_d;
   logic              vote_en_q, vote_en_d;
   logic [11:0]       vote_x_q, vote_x_d, vote_y_q, vote_y_d;
   logic              sstart_q, sstart_d;
   logic              ferr_q, ferr_d;
   logic              vs_rise, last_pix;

   assign vs_rise  = img_vsync & ~vsync_q;
   assign last_pix = img_de && (pix_cnt_q == PIX_LAST);

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      pix_cnt_d   = pix_cnt_q;
      frame_cnt_d = frame_cnt_q;
      skip_cnt_d  = skip_cnt_q;
      vote_en_d   = 1'b0;
      vote_x_d    = vote_x_q;
      vote_y_d    = vote_y_q;
      sstart_d    = 1'b0;
      ferr_d      = 1'b0;

      // A frame start the sequencer cannot take is counted, never acted on.
      if (vs_rise && (state_q == S_CLEAR || state_q == S_SEARCH || state_q == S_DONE) &&
          skip_cnt_q != 8'hFF)
         skip_cnt_d = skip_cnt_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d    = S_CLEAR;
               clr_addr_d = '0;
            end
         end
         S_CLEAR: begin
            if (clr_addr_q == CLR_LAST) begin
               state_d    = S_WAIT_FRM;
               clr_addr_d = '0;   // address reads 0 outside CLEAR
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         S_WAIT_FRM: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (vs_rise) begin
               state_d   = S_VOTE;
               pix_cnt_d = '0;
            end
         end
         S_VOTE: begin
            if (img_de) begin
               pix_cnt_d = pix_cnt_q + 19'd1;
               vote_en_d = edge_bit;
               vote_x_d  = x_axis;
               vote_y_d  = y_axis;
            end
            if (last_pix) begin
               state_d  = S_SEARCH;
               sstart_d = 1'b1;
            end else if (vs_rise) begin
               // Short frame: the partial accumulator is discarded and rebuilt.
               state_d    = S_CLEAR;
               clr_addr_d = '0;
               vote_en_d  = 1'b0;
               ferr_d     = 1'b1;
            end
         end
         S_SEARCH: begin
            if (search_done) begin
               state_d     = S_DONE;
               frame_cnt_d = frame_cnt_q + 16'd1;  // count is current while frame_done is high
            end
         end
         S_DONE: begin
            state_d    = enable ? S_CLEAR : S_IDLE;
            clr_addr_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vsync_q     <= 1'b0;
         clr_addr_q  <= '0;
         pix_cnt_q   <= '0;
         frame_cnt_q <= '0;
         skip_cnt_q  <= '0;
         vote_en_q   <= 1'b0;
         vote_x_q    <= '0;
         vote_y_q    <= '0;
         sstart_q    <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= img_vsync;
         clr_addr_q  <= clr_addr_d;
         pix_cnt_q   <= pix_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         skip_cnt_q  <= skip_cnt_d;
         vote_en_q   <= vote_en_d;
         vote_x_q    <= vote_x_d;
         vote_y_q    <= vote_y_d;
         sstart_q    <= sstart_d;
         ferr_q      <= ferr_d;
      end
   end

   assign acc_clr_en   = (state_q == S_CLEAR);
   assign acc_clr_addr = acc_clr_en ? clr_addr_q : '0;
   assign vote_en      = vote_en_q;
   assign vote_x       = vote_x_q;
   assign vote_y       = vote_y_q;
   assign search_start = sstart_q;
   assign frame_done   = (state_q == S_DONE);
   assign frame_cnt    = frame_cnt_q;
   assign skip_cnt     = skip_cnt_q;
   assign frame_err    = ferr_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_hough_frame_sched.sv
// Bench for hough_frame_sched on a reduced 8x4 frame with a 20-word accumulator.
// A phase-level reference model predicts every output each cycle; directed
// sequences pin key values to hand-computed literals, then random frames follow.
module tb_hough_frame_sched;

   localparam int H = 8, V = 4, DEPTH = 20, AW = 5, TOTAL = H * V;
   localparam int P_IDLE = 0, P_CLEAR = 1, P_WAIT = 2, P_VOTE = 3, P_SEARCH = 4, P_DONE = 5;

   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, img_vsync = 1'b0, img_de = 1'b0;
   logic edge_bit = 1'b0, search_done = 1'b0;
   logic [11:0] x_axis = '0, y_axis = '0;
   logic acc_clr_en, vote_en, search_start, frame_done, frame_err, busy;
   logic [AW-1:0] acc_clr_addr;
   logic [11:0] vote_x, vote_y;
   logic [15:0] frame_cnt;
   logic [7:0] skip_cnt;

   hough_frame_sched #(.H_DISP(H), .V_DISP(V), .ACC_DEPTH(DEPTH), .ACC_AW(AW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .img_vsync(img_vsync), .img_de(img_de),
      .edge_bit(edge_bit), .x_axis(x_axis), .y_axis(y_axis), .search_done(search_done),
      .acc_clr_en(acc_clr_en), .acc_clr_addr(acc_clr_addr), .vote_en(vote_en),
      .vote_x(vote_x), .vote_y(vote_y), .search_start(search_start),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .skip_cnt(skip_cnt),
      .frame_err(frame_err), .busy(busy));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_phase = P_IDLE, m_idx = 0, m_pix = 0;
   bit m_vsd = 0, m_valid = 0, vr;
   int e_vote_en = 0, e_vx = 0, e_vy = 0, e_sstart = 0, e_ferr = 0, e_fcnt = 0, e_skip = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = P_IDLE; m_idx = 0; m_pix = 0; m_vsd = 0;
         e_vote_en = 0; e_vx = 0; e_vy = 0; e_sstart = 0; e_ferr = 0; e_fcnt = 0; e_skip = 0;
         m_valid = 1;
      end else begin
         vr = img_vsync && !m_vsd;
         m_vsd = img_vsync;
         e_vote_en = 0; e_sstart = 0; e_ferr = 0;
         if (vr && (m_phase == P_CLEAR || m_phase == P_SEARCH || m_phase == P_DONE))
            e_skip = (e_skip == 255) ? 255 : e_skip + 1;
         case (m_phase)
            P_IDLE: if (enable) begin m_phase = P_CLEAR; m_idx = 0; end
            P_CLEAR: begin
               m_idx++;
               if (m_idx == DEPTH) begin m_phase = P_WAIT; m_idx = 0; end
            end
            P_WAIT: begin
               if (!enable) m_phase = P_IDLE;
               else if (vr) begin m_phase = P_VOTE; m_pix = 0; end
            end
            P_VOTE: begin
               if (img_de) begin
                  m_pix++; e_vote_en = edge_bit; e_vx = x_axis; e_vy = y_axis;
               end
               if (img_de && m_pix == TOTAL) begin
                  m_phase = P_SEARCH; e_sstart = 1;
               end else if (vr) begin
                  m_phase = P_CLEAR; m_idx = 0; e_vote_en = 0; e_ferr = 1;
               end
            end
            P_SEARCH: if (search_done) begin m_phase = P_DONE; e_fcnt = (e_fcnt + 1) % 65536; end
            default:  begin m_phase = enable ? P_CLEAR : P_IDLE; m_idx = 0; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("acc_clr_en", acc_clr_en, m_phase == P_CLEAR);
         chk("acc_clr_addr", acc_clr_addr, (m_phase == P_CLEAR) ? m_idx : 0);
         chk("vote_en", vote_en, e_vote_en);
         if (e_vote_en != 0) begin
            chk("vote_x", vote_x, e_vx);
            chk("vote_y", vote_y, e_vy);
         end
         chk("search_start", search_start, e_sstart);
         chk("frame_done", frame_done, m_phase == P_DONE);
         chk("frame_cnt", frame_cnt, e_fcnt);
         chk("skip_cnt", skip_cnt, e_skip);
         chk("frame_err", frame_err, e_ferr);
         chk("busy", busy, m_phase != P_IDLE);
         chk("no_overlap", acc_clr_en & vote_en, 0);
      end
   end

   // vote monitor used by the directed literal checks
   int n_votes = 0, last_vx = 0, last_vy = 0;
   always @(negedge clk) begin
      if (vote_en === 1'b1) begin
         n_votes++; last_vx = vote_x; last_vy = vote_y;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic blank(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         search_done = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
         tick();
         search_done = 1'b0;
      end
   endtask

   // Returns in the cycle right after the last pixel was sampled.
   task automatic send_frame(input int npix, input int ex, input int ey, input bit all_e,
                             input bit rnd, input int drop_at);
      img_vsync = 1'b1; tick(); tick(); img_vsync = 1'b0;
      blank(2, rnd);
      for (int p = 0; p < npix; p++) begin
         int px, py;
         px = p % H; py = p / H;
         if (p == drop_at) enable = 1'b0;
         img_de = 1'b1; x_axis = 12'(px); y_axis = 12'(py);
         edge_bit = all_e ? 1'b1 : rnd ? ($urandom_range(0, 3) == 0) : (px == ex && py == ey);
         tick();
         img_de = 1'b0; edge_bit = 1'b0;
         if (p != npix - 1 && px == H - 1) blank(2, rnd);
      end
   endtask

   task automatic wait_clear_end();
      int n;
      n = 0;
      while (acc_clr_en !== 1'b0 && n < 500) begin tick(); n++; end
      chk("clear_end_timeout", n < 500, 1);
   endtask

   int n, v0, c0;

   initial begin
      repeat (20) tick();
      chk("rst_busy", busy, 0);
      chk("rst_clr_en", acc_clr_en, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_vote_x", vote_x, 0);
      rst = 1'b0; tick();

      // clear sweep: exactly DEPTH cycles
      enable = 1'b1; tick();
      n = 0;
      while (acc_clr_en === 1'b1 && n < 1000) begin n++; tick(); end
      chk("clr_cycles", n, 20);
      chk("wait_busy", busy, 1);

      // full frame with a single edge pixel at (3,2)
      v0 = n_votes;
      send_frame(TOTAL, 3, 2, 0, 0, -1);
      chk("sstart_after_last", search_start, 1);
      chk("votes_frame1", n_votes - v0, 1);
      chk("vote_x_lit", last_vx, 3);
      chk("vote_y_lit", last_vy, 2);

      // search_done 50 cycles after search_start
      repeat (49) tick();
      search_done = 1'b1; tick(); search_done = 1'b0;
      chk("frame_done_lit", frame_done, 1);
      chk("frame_cnt1", frame_cnt, 1);
      tick();
      chk("clear_restart", acc_clr_en, 1);

      // frame start during CLEAR is dropped, next frame votes
      v0 = n_votes;
      send_frame(TOTAL, 0, 0, 1, 0, -1);
      chk("skip1", skip_cnt, 1);
      chk("skipped_votes", n_votes - v0, 0);
      v0 = n_votes;
      send_frame(TOTAL, 5, 1, 0, 0, -1);
      chk("votes_frame2", n_votes - v0, 1);
      chk("vote_x2", last_vx, 5);
      chk("vote_y2", last_vy, 1);
      repeat (3) tick();
      search_done = 1'b1; tick(); search_done = 1'b0;
      chk("frame_cnt2", frame_cnt, 2);
      tick();

      // short frame
      wait_clear_end();
      c0 = frame_cnt;
      send_frame(10, 0, 0, 0, 0, -1);
      img_vsync = 1'b1; tick();
      chk("frame_err_lit", frame_err, 1);
      chk("err_to_clear", acc_clr_en, 1);
      chk("err_frame_cnt", frame_cnt, c0);
      img_vsync = 1'b0; tick();
      chk("frame_err_pulse", frame_err, 0);

      // enable dropped mid-VOTE; skip saturation while in SEARCH
      wait_clear_end();
      send_frame(TOTAL, 7, 3, 0, 0, 5);
      chk("sstart_drop", search_start, 1);
      repeat (260) begin img_vsync = 1'b1; tick(); img_vsync = 1'b0; tick(); end
      chk("skip_sat", skip_cnt, 255);
      search_done = 1'b1; tick(); search_done = 1'b0;
      chk("done_after_drop", frame_done, 1);
      chk("frame_cnt3", frame_cnt, 3);
      tick();
      chk("idle_busy", busy, 0);
      search_done = 1'b1; tick(); search_done = 1'b0; tick();
      chk("stray_done_ignored", frame_cnt, 3);

      // reset in the middle of CLEAR
      enable = 1'b1; repeat (5) tick();
      chk("mid_clear", acc_clr_en, 1);
      rst = 1'b1; tick();
      chk("rst_mid_clr_en", acc_clr_en, 0);
      chk("rst_mid_addr", acc_clr_addr, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_fcnt", frame_cnt, 0);
      chk("rst_mid_skip", skip_cnt, 0);
      rst = 1'b0; tick();

      // random frames: full, short, enable drops, random search handshakes
      for (int f = 0; f < 40; f++) begin
         int r, npix, drop;
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 3) != 0) enable = 1'b1;
         npix = (r < 2) ? $urandom_range(1, TOTAL - 1) : TOTAL;
         drop = (r == 9) ? $urandom_range(0, TOTAL - 1) : -1;
         send_frame(npix, 0, 0, 0, 1, drop);
         blank($urandom_range(0, 30), 1);
      end
      enable = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
